regfile_writeback_arbiter: RTL and testbench

Write-side front end for the 3-port register file (two async reads, one sync write on A3/WD3/WE3). Merges the in-order pipeline writeback with results from long-latency units (divider, multi-cycle load) onto the single write port. Buffers long-latency results in a small FIFO. Keeps a per-register pending scoreboard so decode can stall RAW and WAW hazards against outstanding results.

---
 rtl/regfile_writeback_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_regfile_writeback_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter
//
// Write-side front end for the 3-port register file. It merges the in-order
// pipeline writeback with results from long-latency units onto the single
// register file write port (WE3/A3/WD3).
//
// Long-latency results are buffered in a small FIFO. A per-register pending
// scoreboard lets decode stall RAW and WAW hazards against outstanding
// results. The pipeline writeback always has priority. The FIFO head drains
// only on cycles where the pipeline is not writing a real register.
//
// Ports:
//   CLK, RST                   clock and synchronous active-high reset
//   WBE, WBA, WBD              pipeline writeback (enable, register, data)
//   ISSUE_VALID, ISSUE_RD      long-latency op issue and its destination
//   ISSUE_READY                issue may be accepted this cycle
//   LL_VALID, LL_RD, LL_DATA   long-latency result
//   LL_READY                   result FIFO can accept the result
//   Q1, Q2 / BUSY1, BUSY2      scoreboard queries for decode rs1/rs2
//   WE3, A3, WD3               register file write port (combinational)
//   WAW_ERR                    sticky: pipeline wrote a pending register

module regfile_writeback_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WBE,
  input  logic [ADDR_WIDTH-1:0] WBA,
  input  logic [DATA_WIDTH-1:0] WBD,
  input  logic                  ISSUE_VALID,
  input  logic [ADDR_WIDTH-1:0] ISSUE_RD,
  output logic                  ISSUE_READY,
  input  logic                  LL_VALID,
  input  logic [ADDR_WIDTH-1:0] LL_RD,
  input  logic [DATA_WIDTH-1:0] LL_DATA,
  output logic                  LL_READY,
  input  logic [ADDR_WIDTH-1:0] Q1,
  input  logic [ADDR_WIDTH-1:0] Q2,
  output logic                  BUSY1,
  output logic                  BUSY2,
  output logic                  WE3,
  output logic [ADDR_WIDTH-1:0] A3,
  output logic [DATA_WIDTH-1:0] WD3,
  output logic                  WAW_ERR
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [PTR_W:0]      PTR_ONE   = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [PTR_W:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]          rd_ptr_q, rd_ptr_d;
  // Outstanding long-latency ops: issued but not yet drained.
  logic [CNT_W-1:0]        count_q, count_d;
  logic [REG_COUNT-1:0]    pending_q, pending_d;
  logic                    waw_err_q, waw_err_d;

  logic [ADDR_WIDTH-1:0]   fifo_rd_q   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // FIFO status and head
  // ---------------------------------------------------------------------------
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [ADDR_WIDTH-1:0] head_rd;
  logic [DATA_WIDTH-1:0] head_data;

  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    head_rd    = fifo_rd_q[rd_ptr_q[PTR_W-1:0]];
    head_data  = fifo_data_q[rd_ptr_q[PTR_W-1:0]];
  end

  // ---------------------------------------------------------------------------
  // Arbitration and handshakes
  // ---------------------------------------------------------------------------
  logic wb_hit;      // pipeline writes a real register this cycle
  logic pop;         // FIFO head leaves at the next edge
  logic issue_fire;
  logic push;

  always_comb begin
    wb_hit = WBE && (WBA != ADDR_ZERO);
    // A head with rd=0 still pops; it just never asserts WE3.
    pop    = !RST && !wb_hit && !fifo_empty;

    ISSUE_READY = !RST && (count_q < CNT_MAX) &&
                  ((ISSUE_RD == ADDR_ZERO) || !pending_q[ISSUE_RD]);
    LL_READY    = !RST && !fifo_full;

    issue_fire = ISSUE_VALID && ISSUE_READY;
    push       = LL_VALID && LL_READY;
  end

  // Register file write port, zero added latency.
  always_comb begin
    WE3 = 1'b0;
    A3  = head_rd;
    WD3 = head_data;
    if (RST) begin
      WE3 = 1'b0;
    end else if (wb_hit) begin
      WE3 = 1'b1;
      A3  = WBA;
      WD3 = WBD;
    end else if (!fifo_empty) begin
      WE3 = (head_rd != ADDR_ZERO);
    end
  end

  // Scoreboard queries read the registered pending bits, so BUSY only drops
  // once the drained value is already in the register file.
  always_comb begin
    BUSY1   = (Q1 != ADDR_ZERO) && pending_q[Q1];
    BUSY2   = (Q2 != ADDR_ZERO) && pending_q[Q2];
    WAW_ERR = waw_err_q;
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pending_d = pending_q;
    waw_err_d = waw_err_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Issue and drain together leave the count unchanged.
    unique case ({issue_fire, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Clear before set. An issue to the draining register is blocked by
    // ISSUE_READY, so the two never target the same bit.
    if (pop && (head_rd != ADDR_ZERO)) begin
      pending_d[head_rd] = 1'b0;
    end
    if (issue_fire && (ISSUE_RD != ADDR_ZERO)) begin
      pending_d[ISSUE_RD] = 1'b1;
    end

    if (wb_hit && pending_q[WBA]) begin
      waw_err_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      waw_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      waw_err_q <= waw_err_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q[PTR_W-1:0]]   <= LL_RD;
      fifo_data_q[wr_ptr_q[PTR_W-1:0]] <= LL_DATA;
    end
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
module tb_regfile_writeback_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          WBE;
  logic [AW-1:0] WBA;
  logic [DW-1:0] WBD;
  logic          ISSUE_VALID;
  logic [AW-1:0] ISSUE_RD;
  logic          ISSUE_READY;
  logic          LL_VALID;
  logic [AW-1:0] LL_RD;
  logic [DW-1:0] LL_DATA;
  logic          LL_READY;
  logic [AW-1:0] Q1, Q2;
  logic          BUSY1, BUSY2;
  logic          WE3;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD3;
  logic          WAW_ERR;

  regfile_writeback_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(32), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST), .WBE(WBE), .WBA(WBA), .WBD(WBD),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD), .ISSUE_READY(ISSUE_READY),
    .LL_VALID(LL_VALID), .LL_RD(LL_RD), .LL_DATA(LL_DATA), .LL_READY(LL_READY),
    .Q1(Q1), .Q2(Q2), .BUSY1(BUSY1), .BUSY2(BUSY2),
    .WE3(WE3), .A3(A3), .WD3(WD3), .WAW_ERR(WAW_ERR)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: result queue, pending set, outstanding count, sticky flag
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } entry_t;

  entry_t m_q[$];
  bit     m_pend[32];
  int     m_cnt = 0;
  bit     m_waw = 1'b0;

  function automatic bit m_issue_ok();
    return (m_cnt < DEPTH) && (ISSUE_RD == 0 || !m_pend[ISSUE_RD]);
  endfunction

  always @(posedge CLK) begin
    bit wb, drain, iss, psh;
    entry_t e;
    if (RST) begin
      m_q.delete();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_cnt = 0;
      m_waw = 1'b0;
    end else begin
      wb    = WBE && (WBA != 0);
      drain = !wb && (m_q.size() > 0);
      iss   = ISSUE_VALID && m_issue_ok();
      psh   = LL_VALID && (m_q.size() < DEPTH);
      if (wb && m_pend[WBA]) m_waw = 1'b1;
      if (drain) begin
        e = m_q.pop_front();
        m_cnt--;
        if (e.rd != 0) m_pend[e.rd] = 1'b0;
      end
      if (iss) begin
        m_cnt++;
        if (ISSUE_RD != 0) m_pend[ISSUE_RD] = 1'b1;
      end
      if (psh) begin
        e.rd = LL_RD;
        e.data = LL_DATA;
        m_q.push_back(e);
      end
    end
  end

  // Compare every cycle, mid-period, against the model.
  always @(negedge CLK) begin
    if (RST) begin
      chk("rst_we3", {31'b0, WE3}, 0);
      chk("rst_issue_ready", {31'b0, ISSUE_READY}, 0);
      chk("rst_ll_ready", {31'b0, LL_READY}, 0);
    end else begin
      chk("issue_ready", {31'b0, ISSUE_READY}, {31'b0, m_issue_ok()});
      chk("ll_ready", {31'b0, LL_READY}, (m_q.size() < DEPTH) ? 1 : 0);
      chk("busy1", {31'b0, BUSY1}, {31'b0, (Q1 != 0) && m_pend[Q1]});
      chk("busy2", {31'b0, BUSY2}, {31'b0, (Q2 != 0) && m_pend[Q2]});
      chk("waw_err", {31'b0, WAW_ERR}, {31'b0, m_waw});
      if (WBE && WBA != 0) begin
        chk("we3_wb", {31'b0, WE3}, 1);
        chk("a3_wb", {27'b0, A3}, {27'b0, WBA});
        chk("wd3_wb", WD3, WBD);
      end else if (m_q.size() > 0) begin
        chk("we3_drain", {31'b0, WE3}, (m_q[0].rd != 0) ? 1 : 0);
        chk("a3_drain", {27'b0, A3}, {27'b0, m_q[0].rd});
        chk("wd3_drain", WD3, m_q[0].data);
      end else begin
        chk("we3_idle", {31'b0, WE3}, 0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with hand-computed literal expectations
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    RST = 1'b1; WBE = 0; WBA = 0; WBD = 0;
    ISSUE_VALID = 0; ISSUE_RD = 0; LL_VALID = 0; LL_RD = 0; LL_DATA = 0;
    Q1 = 0; Q2 = 0;
    tick(); tick();
    RST = 1'b0;
    settle();
    chk("lit_reset_we3", {31'b0, WE3}, 0);
    chk("lit_reset_busy1", {31'b0, BUSY1}, 0);
    chk("lit_reset_busy2", {31'b0, BUSY2}, 0);
    chk("lit_reset_issue_ready", {31'b0, ISSUE_READY}, 1);
    chk("lit_reset_ll_ready", {31'b0, LL_READY}, 1);
    chk("lit_reset_waw", {31'b0, WAW_ERR}, 0);

    // Pipeline write
    tick();
    WBE = 1; WBA = 5; WBD = 32'hDEADBEEF;
    settle();
    chk("lit_wb_we3", {31'b0, WE3}, 1);
    chk("lit_wb_a3", {27'b0, A3}, 5);
    chk("lit_wb_wd3", WD3, 32'hDEADBEEF);
    tick();
    WBA = 0;
    settle();
    chk("lit_wb_x0_we3", {31'b0, WE3}, 0);
    tick();
    WBE = 0;

    // Issue and drain
    ISSUE_VALID = 1; ISSUE_RD = 7; Q1 = 7;
    settle();
    chk("lit_iss7_ready", {31'b0, ISSUE_READY}, 1);
    chk("lit_iss7_busy_before", {31'b0, BUSY1}, 0);
    tick();
    ISSUE_VALID = 0;
    LL_VALID = 1; LL_RD = 7; LL_DATA = 32'h1234;
    settle();
    chk("lit_iss7_busy", {31'b0, BUSY1}, 1);
    chk("lit_no_bypass_we3", {31'b0, WE3}, 0);
    tick();
    LL_VALID = 0;
    settle();
    chk("lit_drain7_we3", {31'b0, WE3}, 1);
    chk("lit_drain7_a3", {27'b0, A3}, 7);
    chk("lit_drain7_wd3", WD3, 32'h1234);
    chk("lit_drain7_busy_still", {31'b0, BUSY1}, 1);
    tick();
    settle();
    chk("lit_drain7_busy_clear", {31'b0, BUSY1}, 0);

    // Priority: pipeline holds the port while rd=3 waits
    ISSUE_VALID = 1; ISSUE_RD = 3; Q1 = 3;
    tick();
    ISSUE_VALID = 0;
    WBE = 1; WBA = 9; WBD = 32'h99;
    LL_VALID = 1; LL_RD = 3; LL_DATA = 32'hAA;
    settle();
    chk("lit_prio_a3_c1", {27'b0, A3}, 9);
    tick();
    LL_VALID = 0;
    settle();
    chk("lit_prio_a3_c2", {27'b0, A3}, 9);
    tick();
    settle();
    chk("lit_prio_a3_c3", {27'b0, A3}, 9);
    chk("lit_prio_busy3", {31'b0, BUSY1}, 1);
    tick();
    WBE = 0;
    settle();
    chk("lit_prio_drain_a3", {27'b0, A3}, 3);
    chk("lit_prio_drain_wd3", WD3, 32'hAA);
    tick();
    settle();
    chk("lit_prio_busy3_clear", {31'b0, BUSY1}, 0);

    // Capacity
    WBE = 1; WBA = 10; WBD = 32'hA0;
    for (int i = 1; i <= 4; i++) begin
      ISSUE_VALID = 1; ISSUE_RD = AW'(i);
      settle();
      chk("lit_cap_issue_ready", {31'b0, ISSUE_READY}, 1);
      tick();
    end
    ISSUE_RD = 5;
    settle();
    chk("lit_cap_issue_full", {31'b0, ISSUE_READY}, 0);
    ISSUE_VALID = 0;
    for (int i = 1; i <= 4; i++) begin
      LL_VALID = 1; LL_RD = AW'(i); LL_DATA = 32'h100 + DW'(i);
      settle();
      chk("lit_cap_ll_ready", {31'b0, LL_READY}, 1);
      tick();
    end
    LL_VALID = 0;
    settle();
    chk("lit_cap_ll_full", {31'b0, LL_READY}, 0);
    WBE = 0;
    for (int i = 1; i <= 4; i++) begin
      settle();
      chk("lit_cap_drain_we3", {31'b0, WE3}, 1);
      chk("lit_cap_drain_a3", {27'b0, A3}, AW'(i));
      chk("lit_cap_drain_wd3", WD3, 32'h100 + DW'(i));
      tick();
    end
    settle();
    chk("lit_cap_issue_back", {31'b0, ISSUE_READY}, 1);
    chk("lit_cap_idle_we3", {31'b0, WE3}, 0);

    // x0 destination: counted, popped silently
    ISSUE_VALID = 1; ISSUE_RD = 0;
    tick();
    ISSUE_VALID = 0;
    LL_VALID = 1; LL_RD = 0; LL_DATA = 32'h55;
    tick();
    LL_VALID = 0;
    settle();
    chk("lit_x0_head_we3", {31'b0, WE3}, 0);
    chk("lit_x0_head_a3", {27'b0, A3}, 0);
    tick();

    // Hazards
    ISSUE_VALID = 1; ISSUE_RD = 6;
    settle();
    chk("lit_haz_first", {31'b0, ISSUE_READY}, 1);
    tick();
    settle();
    chk("lit_haz_second", {31'b0, ISSUE_READY}, 0);
    ISSUE_VALID = 0;
    WBE = 1; WBA = 6; WBD = 32'h66;
    settle();
    chk("lit_haz_waw_write", {31'b0, WE3}, 1);
    tick();
    WBE = 0;
    settle();
    chk("lit_haz_waw_set", {31'b0, WAW_ERR}, 1);
    tick();
    settle();
    chk("lit_haz_waw_sticky", {31'b0, WAW_ERR}, 1);

    // Reset with two buffered results
    ISSUE_VALID = 1; ISSUE_RD = 8;
    tick();
    ISSUE_VALID = 0;
    WBE = 1; WBA = 10;
    LL_VALID = 1; LL_RD = 6; LL_DATA = 32'h600;
    tick();
    LL_RD = 8; LL_DATA = 32'h800;
    tick();
    LL_VALID = 0; WBE = 0; RST = 1;
    settle();
    chk("lit_rst_we3", {31'b0, WE3}, 0);
    tick();
    RST = 0; Q1 = 6; Q2 = 8;
    settle();
    chk("lit_post_rst_busy1", {31'b0, BUSY1}, 0);
    chk("lit_post_rst_busy2", {31'b0, BUSY2}, 0);
    chk("lit_post_rst_we3", {31'b0, WE3}, 0);
    chk("lit_post_rst_waw", {31'b0, WAW_ERR}, 0);
    tick();
    settle();
    chk("lit_post_rst_we3_2", {31'b0, WE3}, 0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
